// File: rtl/gaussian_3x3_gray8.sv
// 3x3 Gaussian blur [1 2 1;2 4 2;1 2 1]/16 for 8-bit gray video.
// Raster timing is re-emitted aligned with the filtered pixels.
module gaussian_3x3_gray8 #(
  parameter int IMG_WIDTH = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       bypass,
  input  logic [7:0] pixel_in,
  input  logic       vsync,
  input  logic       active_area,
  output logic [7:0] pixel_out,
  output logic       vsync_out,
  output logic       active_out,
  output logic       blur_valid
);

  localparam int CW = (IMG_WIDTH <= 256) ? 8 :
                      (IMG_WIDTH <= 512) ? 9 : 10;
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [9:0] ROW_MAX = 10'd1023;

  logic [7:0] line1 [IMG_WIDTH];
  logic [7:0] line2 [IMG_WIDTH];

  logic [2:0][2:0][7:0] win;
  logic [2:0][2:0][7:0] win_base;

  logic          vsync_prev;
  logic          active_prev;
  logic [CW-1:0] col;
  logic [CW-1:0] col_base;
  logic [AW-1:0] col_idx;
  logic [9:0]    row;
  logic [9:0]    row_base;

  logic       pixel_valid;
  logic       frame_reset;
  logic       line_start;
  logic       line_end;
  logic       clr_win;
  logic [7:0] rd1;
  logic [7:0] rd2;

  logic [7:0]  raw_a;
  logic        ok_a;
  logic [7:0]  raw_b;
  logic        ok_b;
  logic [11:0] sum_c;
  logic [11:0] sum_r;

  logic [2:0] vs_d;
  logic [2:0] act_d;
  logic [2:0] val_d;

  function automatic logic [11:0] tap(
    input logic [7:0] v,
    input int unsigned sh
  );
    return 12'(v) << sh;
  endfunction

  assign pixel_valid = enable & active_area;
  assign frame_reset = vsync_prev & ~vsync;
  assign line_start  = active_area & ~active_prev;
  assign line_end    = ~active_area & active_prev;
  assign clr_win     = frame_reset | line_start;

  // The first sample of a line is accepted in the same cycle as the
  // clear, so it must already see col=0 and an empty window.
  assign col_base = clr_win ? '0 : col;
  assign row_base = frame_reset ? '0 : row;
  assign win_base = clr_win ? '0 : win;
  assign col_idx  = col_base[AW-1:0];

  assign rd1 = line1[col_idx];
  assign rd2 = line2[col_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev  <= 1'b1;
      active_prev <= 1'b0;
    end else begin
      vsync_prev  <= vsync;
      active_prev <= active_area;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
    end else if (pixel_valid && (col_base < COL_MAX)) begin
      col <= col_base + CW'(1);
    end else begin
      col <= col_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
    end else if (frame_reset) begin
      row <= '0;
    end else if (line_end && (row != ROW_MAX)) begin
      row <= row + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      line2[col_idx] <= rd1;
      line1[col_idx] <= pixel_in;
    end
  end

  // Row 0 is the oldest line, column 2 the newest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
    end else if (pixel_valid) begin
      win[0][0] <= win_base[0][1];
      win[0][1] <= win_base[0][2];
      win[0][2] <= rd2;
      win[1][0] <= win_base[1][1];
      win[1][1] <= win_base[1][2];
      win[1][2] <= rd1;
      win[2][0] <= win_base[2][1];
      win[2][1] <= win_base[2][2];
      win[2][2] <= pixel_in;
    end else begin
      win <= win_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_a <= '0;
      ok_a  <= 1'b0;
    end else begin
      raw_a <= pixel_in;
      ok_a  <= (row_base >= 10'd2) && (col_base >= CW'(2));
    end
  end

  always_comb begin
    sum_c = '0;
    sum_c = tap(win[0][0], 0) + tap(win[0][1], 1)
          + tap(win[0][2], 0) + tap(win[1][0], 1)
          + tap(win[1][1], 2) + tap(win[1][2], 1)
          + tap(win[2][0], 0) + tap(win[2][1], 1)
          + tap(win[2][2], 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= '0;
      raw_b <= '0;
      ok_b  <= 1'b0;
    end else begin
      sum_r <= sum_c;
      raw_b <= raw_a;
      ok_b  <= ok_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d  <= 3'b111;
      act_d <= '0;
      val_d <= '0;
    end else begin
      vs_d  <= {vs_d[1:0], vsync};
      act_d <= {act_d[1:0], active_area};
      val_d <= {val_d[1:0], pixel_valid};
    end
  end

  // Max sum is 4080, so the rounded result never exceeds 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out <= '0;
    end else if (!val_d[1]) begin
      pixel_out <= '0;
    end else if (bypass || !ok_b) begin
      pixel_out <= raw_b;
    end else begin
      pixel_out <= 8'((sum_r + 12'd8) >> 4);
    end
  end

  assign vsync_out  = vs_d[2];
  assign active_out = act_d[2];
  assign blur_valid = val_d[2];

endmodule

// File: tb/tb_gaussian_3x3_gray8.sv
// Randomised scoreboard bench for gaussian_3x3_gray8.
// Expected pixels come from a frame-level kernel model.
module tb_gaussian_3x3_gray8;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       bypass = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic       vsync = 1'b1;
  logic       active_area = 1'b0;
  logic [7:0] pixel_out;
  logic       vsync_out;
  logic       active_out;
  logic       blur_valid;

  gaussian_3x3_gray8 #(.IMG_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bypass      (bypass),
    .pixel_in    (pixel_in),
    .vsync       (vsync),
    .active_area (active_area),
    .pixel_out   (pixel_out),
    .vsync_out   (vsync_out),
    .active_out  (active_out),
    .blur_valid  (blur_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] filt;
  } exp_t;

  exp_t       q[$];
  logic [7:0] img [H][W];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] filt(input int x, input int y);
    int s;
    if (x < 2 || y < 2) return img[y][x];
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1)
             * int'(img[y-2+i][x-2+j]);
    return 8'((s + 8) / 16);
  endfunction

  // Monitor: outputs must equal inputs sampled two edges earlier.
  initial begin
    logic [2:0] hvs;
    logic [2:0] hac;
    logic [2:0] hpv;
    logic       b;
    logic       prev_act;
    int         cnt;
    exp_t       e;
    hvs = 3'b111;
    hac = '0;
    hpv = '0;
    prev_act = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        hvs = 3'b111;
        hac = '0;
        hpv = '0;
        prev_act = 1'b0;
        cnt = 0;
      end else begin
        hvs = {hvs[1:0], vsync};
        hac = {hac[1:0], active_area};
        hpv = {hpv[1:0], enable & active_area};
        b = bypass;
        #1;
        check("vsync_out", int'(vsync_out), int'(hvs[2]));
        check("active_out", int'(active_out), int'(hac[2]));
        check("blur_valid", int'(blur_valid), int'(hpv[2]));
        if (blur_valid) begin
          cnt++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow actual=%0d required=none",
                     pixel_out);
          end else begin
            e = q.pop_front();
            check("pixel", int'(pixel_out),
                  int'(b ? e.raw : e.filt));
          end
        end else begin
          check("idle_zero", int'(pixel_out), 0);
        end
        if (prev_act && !active_out) begin
          check("line_count", cnt, W);
          cnt = 0;
        end
        prev_act = active_out;
      end
    end
  end

  task automatic step(input logic vs, input logic a, input logic e,
                      input logic [7:0] p, input logic byp);
    @(negedge clk);
    vsync = vs;
    active_area = a;
    enable = e;
    pixel_in = p;
    bypass = byp;
  endtask

  function automatic logic rb(input int mode);
    if (mode == 3) return 1'b1;
    if (mode == 4) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic do_reset();
    #1;
    rst = 1'b1;
    active_area = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_pixel", int'(pixel_out), 0);
    check("rst_active", int'(active_out), 0);
    check("rst_valid", int'(blur_valid), 0);
    check("rst_vsync", int'(vsync_out), 1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode: 0 flat, 1 impulse, 2 gated ramp, 3 bypass,
  // 4 bypass toggling, 5 random enable gaps
  task automatic run_frame(input int mode, input int rr, input int rc);
    int g;
    logic byp;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0: img[y][x] = 8'h80;
          1: img[y][x] = (x == 3 && y == 3) ? 8'hFF : 8'h00;
          2: img[y][x] = 8'(16 * x + y);
          default: img[y][x] = 8'($urandom);
        endcase
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        g = 0;
        if (mode == 2 && x == 4) g = 3;
        if (mode == 5 && $urandom_range(0, 3) == 0)
          g = int'($urandom_range(1, 2));
        repeat (g) step(1'b0, 1'b1, 1'b0, 8'($urandom), rb(mode));
        byp = rb(mode);
        step(1'b0, 1'b1, 1'b1, img[y][x], byp);
        q.push_back('{img[y][x], filt(x, y)});
        if (y == rr && x == rc) begin
          do_reset();
          return;
        end
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, rb(mode));
    end
    repeat (4) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("init_pixel", int'(pixel_out), 0);
    check("init_active", int'(active_out), 0);
    check("init_valid", int'(blur_valid), 0);
    check("init_vsync", int'(vsync_out), 1);
    rst = 1'b0;
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    run_frame(2, -1, -1);
    run_frame(3, -1, -1);
    run_frame(4, -1, -1);
    run_frame(5, -1, -1);
    run_frame(5, 3, 4);
    run_frame(4, -1, -1);
    run_frame(1, -1, -1);
    repeat (4) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gaussian_3x3_gray8.md
Name: gaussian_3x3_gray8

Overview:
- 3x3 Gaussian smoothing stage for 8-bit grayscale video streams. Kernel is [1 2 1; 2 4 2; 1 2 1]/16.
- Sits directly upstream of the Canny edge detector to suppress sensor noise before gradient computation.
- Consumes the same vsync/active_area raster timing and re-emits it, delayed and aligned with the filtered pixels, so the Canny stage can be driven unchanged.

Parameters:
- IMG_WIDTH, 320, active pixels per line; sets line-buffer depth. Column counter width: 8 bits if ≤256, 9 bits if ≤512, else 10 bits.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  pixel qualifier; pixel_valid = enable & active_area.
- bypass  input  1  when 1, pixel_out carries the unfiltered sample at the same latency.
- pixel_in  input  8  grayscale sample.
- vsync  input  1  frame sync; falling edge starts a frame.
- active_area  input  1  high during active pixels of a line.
- pixel_out  output  8  filtered pixel.
- vsync_out  output  1  vsync delayed to align with pixel_out.
- active_out  output  1  active_area delayed to align with pixel_out.
- blur_valid  output  1  pixel_valid delayed to align with pixel_out.

Behaviour:
- Reset (async, rst=1): every register clears to 0, including pixel_out, active_out, blur_valid, counters and window taps. Exceptions: vsync_prev and the vsync delay chain reset to 1, so vsync_out=1 during and after reset. Line-buffer contents are don't-care.
- Edge detection uses registered vsync_prev and active_prev.
  - frame_reset = vsync_prev & ~vsync.
  - line_start = active_area & ~active_prev.
  - line_end = ~active_area & active_prev.
- frame_reset: clears col, row and all window taps. It has priority over line_start and line_end in the same cycle.
- line_start: clears col and the 9 window taps to 0.
- line_end: row increments, saturating at 1023.
- Column counter:
  - col is the index of the sample being accepted.
  - Increments on pixel_valid while col < IMG_WIDTH-1; holds at IMG_WIDTH-1 for excess pixels.
- Stage A (edge N, pixel_valid=1):
  - line2[col] <= line1[col]; line1[col] <= pixel_in.
  - Shift the three tap rows: current row from pixel_in, middle row from the line1 tap, top row from the line2 tap.
  - Register win_ok = (row ≥ 2) & (col ≥ 2) and raw = pixel_in.
  - When pixel_valid=0, the window and line buffers hold.
- Stage B (edge N+1): sum_r <= weighted sum of the 9 taps, 12 bits unsigned (max 4080). Carry raw and win_ok forward.
- Stage C (edge N+2): pixel_out is chosen as follows.
  - If the delayed pixel_valid = 0: pixel_out = 0.
  - Else if bypass = 1 or win_ok = 0: pixel_out = raw.
  - Otherwise: pixel_out = (sum_r + 8) >> 4, 12-bit add, result always ≤ 255, no clamp needed.
- Latency: a sample taken at edge N is visible on pixel_out after edge N+2.
  - vsync, active_area and pixel_valid each pass through a 3-register delay chain so that vsync_out, active_out and blur_valid update at the same edge as pixel_out.
- Filtered output at sample (x,y) is centered on input pixel (x-1, y-1).
  - Rows 0–1 and columns 0–1 of each frame are border outputs and pass the raw sample through, with no zero-injection, to avoid false edges downstream.
- enable low mid-line: no window shift, no col advance, blur_valid low for the matching cycles. Resuming produces results identical to an ungated stream.
- bypass is sampled at stage C and may change at any cycle; the change takes effect on that edge's output.
- rst asserted mid-line: outputs clear immediately (asynchronously). After release, processing restarts cleanly from the next vsync falling edge.
  - Until that edge, row=0, so all output is border pass-through.

Test Plan:
- Async reset: assert rst mid-line between edges → pixel_out=0, active_out=0, blur_valid=0, vsync_out=1 before the next edge. Release, run a full frame → normal output.
- Flat field: IMG_WIDTH=8, 8x6 frame of 0x80 → every blur_valid pixel, border and interior, equals 0x80.
- Impulse: all 0 except 0xFF at input (3,3), IMG_WIDTH=8 → outputs for centers (x,y) appear at output sample (x+1, y+1).
  - Center (3,3) = 0x40.
  - (2,3), (4,3), (3,2), (3,4) = 0x20.
  - Diagonals = 0x10.
  - All others 0x00.
- Latency/timing: active_area rises at edge N → active_out rises after edge N+2. blur_valid pulse count per line = 8. vsync_out falls exactly 2 edges after vsync is sampled low.
- Enable gating: ramp image (pixel = 16x + y) with enable dropped for 3 cycles at x=4 → blur_valid low for those 3 cycles. Valid pixel sequence is bit-identical to the ungated run.
- Bypass: bypass=1, random pixels → pixel_out equals pixel_in from 2 edges earlier whenever blur_valid=1. Toggling bypass mid-line switches between raw and filtered values on the same edge.
